// File: rtl/csel_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : csel_adder_pipe
//  Description : Pipelined carry-select adder/subtractor. Each stage resolves
//                one BLOCK-bit segment by choosing between two precomputed
//                candidate sums with the carry registered by the stage before.
//                A valid/ready handshake freezes the whole pipe on stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module csel_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = WIDTH / BLOCK;

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_eff;

    // Subtraction is a + ~b + ~borrow_in.
    assign w_b_eff = sub ? ~b : b;
    assign w_c_eff = cin ^ sub;

    // One global enable: every stage moves together or holds together.
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        // Operand bits still to be consumed arriving at this stage, and
        // resolved sum bits leaving it.
        localparam int RIN  = WIDTH - k * BLOCK;
        localparam int SOUT = (k + 1) * BLOCK;

        logic [RIN-1:0]  w_a_in;
        logic [RIN-1:0]  w_b_in;
        logic            w_c_in;
        logic            w_v_in;
        logic [BLOCK:0]  w_s0;
        logic [BLOCK:0]  w_s1;
        logic [BLOCK:0]  w_sel;
        logic            r_v;
        logic            r_c;
        logic [SOUT-1:0] r_s;

        // Both candidate sums for the current segment; carry picks one.
        assign w_s0  = {1'b0, w_a_in[BLOCK-1:0]} + {1'b0, w_b_in[BLOCK-1:0]};
        assign w_s1  = w_s0 + {{BLOCK{1'b0}}, 1'b1};
        assign w_sel = w_c_in ? w_s1 : w_s0;

        // Beat valid bit and segment carry-out.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
            end else if (w_adv) begin
                r_v <= w_v_in;
                r_c <= w_sel[BLOCK];
            end
        end

        if (k == 0) begin : g_head
            assign w_a_in = a;
            assign w_b_in = w_b_eff;
            assign w_c_in = w_c_eff;
            assign w_v_in = in_valid;

            // First resolved segment.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s <= '0;
                end else if (w_adv) begin
                    r_s <= w_sel[BLOCK-1:0];
                end
            end
        end else begin : g_body
            assign w_a_in = g_stage[k-1].g_fwd.r_a;
            assign w_b_in = g_stage[k-1].g_fwd.r_b;
            assign w_c_in = g_stage[k-1].r_c;
            assign w_v_in = g_stage[k-1].r_v;

            // Append this segment above the ones resolved upstream.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s <= '0;
                end else if (w_adv) begin
                    r_s <= {w_sel[BLOCK-1:0], g_stage[k-1].r_s};
                end
            end
        end

        if (k < NSEG - 1) begin : g_fwd
            logic [RIN-BLOCK-1:0] r_a;
            logic [RIN-BLOCK-1:0] r_b;

            // Skew registers carrying the unconsumed operand segments.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_in[RIN-1:BLOCK];
                    r_b <= w_b_in[RIN-1:BLOCK];
                end
            end
        end else begin : g_last
            logic r_ovf;

            // Carry into the MSB is a^b^sum at that bit; xor with carry-out.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_a_in[BLOCK-1] ^ w_b_in[BLOCK-1]
                           ^ w_sel[BLOCK-1] ^ w_sel[BLOCK];
                end
            end
        end
    end

    assign out_valid = g_stage[NSEG-1].r_v;
    assign sum       = g_stage[NSEG-1].r_s;
    assign cout      = g_stage[NSEG-1].r_c;
    assign ovf       = g_stage[NSEG-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: doc/csel_adder_pipe.md
Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor. It supersedes the fixed 8/16/32/64-bit combinational carry-select adders.
- Each pipeline stage resolves one BLOCK-bit segment. Both candidate segment sums (carry-in 0 and carry-in 1) are precomputed, and the registered carry from the previous stage selects between them.
- Adds carry-in, subtract mode and a signed-overflow flag.
- Uses a valid/ready stream handshake so it can sit between datapath producers and consumers that may stall.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of BLOCK.
- BLOCK, 8, segment width in bits; one pipeline stage per segment; 1 <= BLOCK <= WIDTH.
- NSEG (localparam, not overridable), WIDTH/BLOCK, number of stages; equals the latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept an operand beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (borrow-in when sub=1)
- sub  input  1  0: A+B+cin; 1: A-B-cin
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out of MSB (in sub mode, 1 = no borrow)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Operand conditioning at accept:
  - b_eff = sub ? ~b : b.
  - c_eff = sub ? ~cin : cin.
  - The result is therefore a + b_eff + c_eff, truncated to WIDTH bits.
- Accept and advance rules:
  - An operand beat is accepted when in_valid & in_ready.
  - in_ready = out_ready | ~out_valid. This is a combinational path from out_ready and is permitted.
  - The pipeline is globally enabled: advance = in_ready. When advance = 0, every stage register (valid bits, data, carries) holds its value.
- Stage k (k = 0..NSEG-1):
  - Computes segment bits [k*BLOCK +: BLOCK] as s0 = a_seg + b_seg + 0 and s1 = a_seg + b_seg + 1.
  - Selects s0 or s1 using the carry registered by stage k-1; stage 0 uses c_eff.
  - Registers the selected segment, its carry-out and a valid bit.
  - Operand segments not yet consumed travel with the beat through skew registers. Already-resolved sum segments also travel with the beat to the output.
- Latency and throughput:
  - Latency is exactly NSEG cycles from the accept edge to out_valid=1, with no stall in between.
  - Throughput is one result per cycle while out_ready=1.
  - Results emerge in acceptance order. Bubbles (in_valid=0) propagate as valid=0 slots.
- Output flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. The final stage captures the carry into the MSB.
- Output registers:
  - sum, cout and ovf are registered.
  - Their values are meaningful only while out_valid=1.
  - They remain stable while out_valid=1 and out_ready=0.
- Reset:
  - Asserting rst immediately clears all stage valid bits, out_valid, sum, cout, ovf and all carry registers to 0.
  - In-flight beats are discarded and no stale result ever appears after release.
  - in_ready = 1 during and after reset, since out_valid = 0.
- Boundary conditions:
  - BLOCK = WIDTH gives a single-stage registered adder with latency 1.
  - A carry generated in segment 0 must propagate correctly through all NSEG stages, e.g. all-ones + cin.
  - Simultaneous output accept and input accept in the same cycle is legal and loses no data.

Test Plan:
- WIDTH=32, BLOCK=8: a=0xA0A0FFFF, b=0xA0BFFFE0, cin=0, sub=0. Required: after 4 cycles sum=0x4160FFDF, cout=1, ovf=1.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000000, cin=1. Required: sum=0x00000000, cout=1, ovf=0. The carry must cross all 4 stages.
- Subtract:
  - a=5, b=7, sub=1, cin=0: sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1, sub=1: sum=0x7FFFFFFF, cout=1, ovf=1.
  - a=10, b=3, sub=1, cin=1: sum=6, cout=1.
- Streaming with out_ready=1: 10 back-to-back random beats. Required: first out_valid in cycle 4, then one result per cycle, in order, all matching the reference model. Repeat with WIDTH=64, BLOCK=16 (998+128=1126, latency 4) and with BLOCK=WIDTH (latency 1).
- Backpressure: hold out_ready=0 for 3 cycles while out_valid=1. Required: in_ready=0; sum/cout/ovf stable; pipeline frozen. After release, no beats are lost or duplicated and order is preserved.
- Reset mid-flight: assert rst asynchronously (off clock edge) with 3 beats in flight. Required: out_valid=0 and outputs 0 immediately. After release, no results appear until new beats are accepted and NSEG cycles elapse.
